// File: rtl/adder_pipe_param.sv
// Pipelined N-bit add/subtract; the carry chain is cut into P_STAGES registered ripple segments.
// Latency: P_STAGES cycles from accept to oVALID; one operation per cycle while iREADY stays high.
// Backpressure: global stall, all stages hold while oVALID && !iREADY; oREADY = !oVALID || iREADY.
module adder_pipe_param #(
    parameter int P_WIDTH     = 32,
    parameter int P_STAGES    = 4,
    parameter int P_TAG_WIDTH = 4
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET_SYNC,
    input  logic                   iVALID,
    output logic                   oREADY,
    input  logic                   iSUB,
    input  logic                   iCARRY,
    input  logic [P_TAG_WIDTH-1:0] iTAG,
    input  logic [P_WIDTH-1:0]     iDATA_A,
    input  logic [P_WIDTH-1:0]     iDATA_B,
    output logic                   oVALID,
    input  logic                   iREADY,
    output logic [P_WIDTH-1:0]     oDATA,
    output logic [P_TAG_WIDTH-1:0] oTAG,
    output logic                   oC,
    output logic                   oV,
    output logic                   oN,
    output logic                   oZ
);
    localparam int SW = P_WIDTH / P_STAGES;

    if ((P_STAGES < 1) || (P_STAGES > P_WIDTH) || ((P_WIDTH % P_STAGES) != 0)) begin : g_param_check
        $error("adder_pipe_param: P_STAGES must be in 1..P_WIDTH and divide P_WIDTH");
    end

    // Per-stage registers; a_q/b_q carry the operand bits still to be summed downstream.
    logic [P_WIDTH-1:0]     a_q   [P_STAGES];
    logic [P_WIDTH-1:0]     b_q   [P_STAGES];
    logic [P_WIDTH-1:0]     s_q   [P_STAGES];
    logic                   cy_q  [P_STAGES];
    logic                   vld_q [P_STAGES];
    logic [P_TAG_WIDTH-1:0] tag_q [P_STAGES];
    logic                   v_q;

    logic [P_WIDTH-1:0]     a_in   [P_STAGES];
    logic [P_WIDTH-1:0]     b_in   [P_STAGES];
    logic [P_WIDTH-1:0]     s_nxt  [P_STAGES];
    logic                   cy_in  [P_STAGES];
    logic                   cy_nxt [P_STAGES];
    logic [SW:0]            seg;
    logic                   v_nxt;
    logic                   advance;

    assign advance = !vld_q[P_STAGES-1] || iREADY;
    assign oREADY  = advance;

    always_comb begin
        seg   = '0;
        v_nxt = 1'b0;
        // Subtract is A + ~B + ~borrow, so only stage 0 ever sees the raw operands.
        a_in[0]  = iDATA_A;
        b_in[0]  = iSUB ? ~iDATA_B : iDATA_B;
        cy_in[0] = iSUB ^ iCARRY;
        s_nxt[0] = '0;
        for (int k = 1; k < P_STAGES; k++) begin
            a_in[k]  = a_q[k-1];
            b_in[k]  = b_q[k-1];
            cy_in[k] = cy_q[k-1];
            s_nxt[k] = s_q[k-1];
        end
        for (int k = 0; k < P_STAGES; k++) begin
            seg = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]} + {{SW{1'b0}}, cy_in[k]};
            s_nxt[k][k*SW +: SW] = seg[SW-1:0];
            cy_nxt[k] = seg[SW];
            // Carry into the MSB is recovered from the last segment's sum bit and operand MSBs.
            if (k == P_STAGES - 1) begin
                v_nxt = seg[SW] ^ seg[SW-1] ^ a_in[k][P_WIDTH-1] ^ b_in[k][P_WIDTH-1];
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            for (int k = 0; k < P_STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
                vld_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end
            v_q <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= iVALID;
            tag_q[0] <= iTAG;
            for (int k = 1; k < P_STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            for (int k = 0; k < P_STAGES; k++) begin
                a_q[k]  <= a_in[k];
                b_q[k]  <= b_in[k];
                s_q[k]  <= s_nxt[k];
                cy_q[k] <= cy_nxt[k];
            end
            v_q <= v_nxt;
        end
    end

    assign oVALID = vld_q[P_STAGES-1];
    assign oDATA  = s_q[P_STAGES-1];
    assign oTAG   = tag_q[P_STAGES-1];
    assign oC     = cy_q[P_STAGES-1];
    assign oV     = v_q;
    assign oN     = oDATA[P_WIDTH-1];
    assign oZ     = (oDATA == '0);

endmodule
